// File: rtl/btn_pkg.sv
// Shared constants for button-path blocks: state encoding and default ms timing.
package btn_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        GAP    = ST_GAP,
        PRESS2 = ST_PRESS2,
        HOLD   = ST_HOLD
    } state_t;

    localparam int TICK_DIV_DEF  = 100_000;
    localparam int LONG_MS_DEF   = 1000;
    localparam int DOUBLE_MS_DEF = 250;
    localparam int REPEAT_MS_DEF = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level in, gesture pulses and busy flag out.
interface btn_event_decoder_if;
    logic i_btn_level;
    logic o_short;
    logic o_double;
    logic o_long;
    logic o_repeat;
    logic o_busy;

    modport master (output i_btn_level, input o_short, o_double, o_long, o_repeat, o_busy);
    modport slave  (input i_btn_level, output o_short, o_double, o_long, o_repeat, o_busy);
endinterface

// File: rtl/tick_gen.sv
// Free-running divider: o_tick is high for one clk every DIV clocks.
module tick_gen #(
    parameter int DIV = btn_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + W'(1);
    end

    assign o_tick = (cnt == LAST);
endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced button gestures into short/double/long/repeat pulses.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int LONG_MS   = LONG_MS_DEF,
    parameter int DOUBLE_MS = DOUBLE_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    btn_event_decoder_if.slave  bus
);
    localparam int MS_W = $clog2(max3(LONG_MS, DOUBLE_MS, REPEAT_MS)) + 1;
    localparam logic [MS_W-1:0] LONG_END = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] DBL_END  = MS_W'(DOUBLE_MS - 1);
    localparam logic [MS_W-1:0] REP_END  = MS_W'(REPEAT_MS - 1);
    localparam logic [MS_W-1:0] MS_SAT   = '1;

    state_t          state, state_nx;
    logic [MS_W-1:0] ms;
    logic            tick, lvl, ms_clr;
    logic            short_nx, dbl_nx, long_nx, rep_nx;
    logic            short_q, dbl_q, long_q, rep_q, busy_q;

    tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .o_tick(tick));

    assign lvl = bus.i_btn_level;

    // Level changes are tested first so they win over a coincident timeout.
    always_comb begin
        state_nx = state;
        ms_clr   = 1'b0;
        short_nx = 1'b0;
        dbl_nx   = 1'b0;
        long_nx  = 1'b0;
        rep_nx   = 1'b0;
        case (state)
            IDLE:   if (lvl) state_nx = PRESS1;
            PRESS1: if (!lvl) state_nx = GAP;
                    else if (tick && ms == LONG_END) begin long_nx = 1'b1; state_nx = HOLD; end
            GAP:    if (lvl) state_nx = PRESS2;
                    else if (tick && ms == DBL_END) begin short_nx = 1'b1; state_nx = IDLE; end
            PRESS2: if (!lvl) begin dbl_nx = 1'b1; state_nx = IDLE; end
                    else if (tick && ms == LONG_END) begin long_nx = 1'b1; state_nx = HOLD; end
            HOLD:   if (!lvl) state_nx = IDLE;
                    else if (tick && ms == REP_END) begin rep_nx = 1'b1; ms_clr = 1'b1; end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ms      <= '0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state || ms_clr) ms <= '0;
            else if (tick && ms != MS_SAT)   ms <= ms + MS_W'(1);
            short_q <= short_nx;
            dbl_q   <= dbl_nx;
            long_q  <= long_nx;
            rep_q   <= rep_nx;
            busy_q  <= (state != IDLE);
        end
    end

    assign bus.o_short  = short_q;
    assign bus.o_double = dbl_q;
    assign bus.o_long   = long_q;
    assign bus.o_repeat = rep_q;
    assign bus.o_busy   = busy_q;
endmodule
